timer_counter: RTL and testbench



---
 rtl/timer_counter.sv | 92 +++++++++
 tb/tb_timer_counter.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/timer_counter.sv
// One-shot down-counter with prescaled ticks and a single-cycle Ovf5 done pulse.
// Define TIMER_COUNTER_RESTART_EN to let Start during RUN reload the count.
module timer_counter #(
  parameter int WIDTH    = 5,
  parameter int PRESCALE = 1
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Start,
  input  logic [WIDTH-1:0] EX_time,
  output logic             Ovf5,
  output logic             Busy,
  output logic [WIDTH-1:0] Count
);

  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PMAX = PW'(PRESCALE - 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t           state, state_n;
  logic [PW-1:0]    pre, pre_n;
  logic [WIDTH-1:0] cnt_n;
  logic [WIDTH-1:0] ld_val;
  logic             ovf_n;
  logic             busy_n;
  logic             tick;

  // A zero exposure still lasts one tick
  assign ld_val = (EX_time == '0) ? WIDTH'(1) : EX_time;
  assign tick   = (pre == PMAX);

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state <= IDLE;
      pre   <= '0;
      Count <= '0;
      Ovf5  <= 1'b0;
      Busy  <= 1'b0;
    end else begin
      state <= state_n;
      pre   <= pre_n;
      Count <= cnt_n;
      Ovf5  <= ovf_n;
      Busy  <= busy_n;
    end
  end

  always_comb begin
    state_n = state;
    pre_n   = pre;
    cnt_n   = Count;
    ovf_n   = 1'b0;
    busy_n  = Busy;
    case (state)
      IDLE: begin
        if (Start) begin
          cnt_n   = ld_val;
          pre_n   = '0;
          busy_n  = 1'b1;
          state_n = RUN;
        end
      end
      RUN: begin
`ifdef TIMER_COUNTER_RESTART_EN
        if (Start) begin
          cnt_n = ld_val;
          pre_n = '0;
        end else
`endif
        if (tick) begin
          pre_n = '0;
          if (Count == WIDTH'(1)) begin
            cnt_n   = '0;
            ovf_n   = 1'b1;
            busy_n  = 1'b0;
            state_n = IDLE;
          end else begin
            cnt_n = Count - WIDTH'(1);
          end
        end else begin
          pre_n = pre + PW'(1);
        end
      end
      default: begin
        state_n = IDLE;
        busy_n  = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_timer_counter.sv
// Bench for timer_counter: two prescale settings share stimulus and
// are compared each cycle against a cycle-arithmetic exposure model.
module tb_timer_counter;

  logic       Clk;
  logic       Reset;
  logic       Start;
  logic [4:0] EX_time;
  logic [1:0] ovf;
  logic [1:0] busy;
  logic [4:0] cnt0, cnt1;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  int m_run   [2];
  int m_start [2];
  int m_eff   [2];
  int m_cnt   [2];
  int m_ovf   [2];

  timer_counter #(.WIDTH(5), .PRESCALE(1)) u_p1 (
    .Clk(Clk), .Reset(Reset), .Start(Start), .EX_time(EX_time),
    .Ovf5(ovf[0]), .Busy(busy[0]), .Count(cnt0)
  );

  timer_counter #(.WIDTH(5), .PRESCALE(3)) u_p3 (
    .Clk(Clk), .Reset(Reset), .Start(Start), .EX_time(EX_time),
    .Ovf5(ovf[1]), .Busy(busy[1]), .Count(cnt1)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s cyc=%0d obs=%0h exp=%0h", tag, cyc, obs, exp);
    end
  endtask

  // Exposure model: the pulse lands eff*P edges after the accepting edge
  task automatic model_edge(input logic st, input logic rs,
                            input logic [4:0] ex);
    int p, el, eff;
    eff = (ex == 0) ? 1 : int'(ex);
    for (int d = 0; d < 2; d++) begin
      p = (d == 0) ? 1 : 3;
      m_ovf[d] = 0;
      if (rs) begin
        m_run[d] = 0;
        m_cnt[d] = 0;
      end else if (m_run[d] != 0) begin
        el = cyc - m_start[d];
`ifdef TIMER_COUNTER_RESTART_EN
        if (st) begin
          m_start[d] = cyc;
          m_eff[d]   = eff;
          m_cnt[d]   = eff;
        end else
`endif
        if (el == m_eff[d] * p) begin
          m_ovf[d] = 1;
          m_run[d] = 0;
          m_cnt[d] = 0;
        end else begin
          m_cnt[d] = m_eff[d] - el / p;
        end
      end else if (st) begin
        m_run[d]   = 1;
        m_start[d] = cyc;
        m_eff[d]   = eff;
        m_cnt[d]   = eff;
      end
    end
  endtask

  task automatic step(input logic st, input logic rs, input logic [4:0] ex);
    Start   = st;
    Reset   = rs;
    EX_time = ex;
    @(posedge Clk);
    cyc++;
    model_edge(st, rs, ex);
    #1;
    chk("ovf_p1",  32'(ovf[0]),  32'(m_ovf[0]));
    chk("busy_p1", 32'(busy[0]), 32'(m_run[0]));
    chk("cnt_p1",  32'(cnt0),    32'(m_cnt[0]));
    chk("ovf_p3",  32'(ovf[1]),  32'(m_ovf[1]));
    chk("busy_p3", 32'(busy[1]), 32'(m_run[1]));
    chk("cnt_p3",  32'(cnt1),    32'(m_cnt[1]));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 5'd0);
  endtask

  initial begin
    int last_p, found;
    for (int d = 0; d < 2; d++) begin
      m_run[d] = 0; m_start[d] = 0; m_eff[d] = 0;
      m_cnt[d] = 0; m_ovf[d] = 0;
    end
    Start = 1'b0; Reset = 1'b1; EX_time = 5'd0;

    // reset, including Start coincident with Reset
    step(1'b0, 1'b1, 5'd3);
    step(1'b1, 1'b1, 5'd7);
    step(1'b0, 1'b1, 5'd3);
    idle(3);

    // nominal run, then 0/1/31 boundaries
    step(1'b1, 1'b0, 5'd10);
    idle(32);
    step(1'b1, 1'b0, 5'd0);
    idle(5);
    step(1'b1, 1'b0, 5'd1);
    idle(5);
    step(1'b1, 1'b0, 5'd31);
    idle(95);

    // Start mid-run
    step(1'b1, 1'b0, 5'd10);
    idle(3);
    step(1'b1, 1'b0, 5'd6);
    idle(40);

    // Reset mid-run, then a fresh run
    step(1'b1, 1'b0, 5'd10);
    idle(4);
    step(1'b0, 1'b1, 5'd10);
    idle(15);
    step(1'b1, 1'b0, 5'd4);
    idle(15);

    // back-to-back runs: Start on the 31st edge after each pulse
    last_p = -1;
    for (int r = 0; r < 4; r++) begin
      step(1'b1, 1'b0, 5'd10);
      found = 0;
      for (int i = 0; i < 50 && found == 0; i++) begin
        step(1'b0, 1'b0, 5'd0);
        if (ovf[0] === 1'b1) found = 1;
      end
      chk("pulse_seen", 32'(found), 32'd1);
      if (last_p >= 0) chk("pulse_spacing", 32'(cyc - last_p), 32'd41);
      last_p = cyc;
      idle(30);
    end

    // randomized traffic
    for (int i = 0; i < 1500; i++)
      step(($urandom_range(7) == 0), ($urandom_range(63) == 0),
           5'($urandom));
    idle(100);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
